// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: per-operand forwarding selects, load-use bubble
// insertion with a configurable bubble count, and a memory-busy freeze.
module hazard_forward_unit #(
  parameter int RAW        = 5,
  parameter int NSRC       = 2,
  parameter int LD_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*RAW-1:0]   id_ex_src,
  input  logic [NSRC*RAW-1:0]   if_id_src,
  input  logic [RAW-1:0]        id_ex_rw,
  input  logic                  id_ex_memread,
  input  logic [RAW-1:0]        ex_mem_rw,
  input  logic                  ex_mem_regwrite,
  input  logic [RAW-1:0]        mem_wb_rw,
  input  logic                  mem_wb_regwrite,
  input  logic                  mem_busy,
  output logic [2*NSRC-1:0]     f_ctrl,
  output logic                  stall,
  output logic                  bubble,
  output logic                  freeze,
  output logic [15:0]           stall_cnt
);

  typedef enum logic {RUN, LDSTALL} state_t;

  localparam logic [2:0] BCNT_INIT = 3'(LD_BUBBLES - 1);

  state_t         state, state_nxt;
  logic [2:0]     bcnt, bcnt_nxt;
  logic [RAW-1:0] hold_rw;
  logic           hold_vld;
  logic           load_use;

  always_comb begin
    load_use = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (if_id_src[i*RAW +: RAW] == id_ex_rw) load_use = 1'b1;
    end
    load_use = load_use && id_ex_memread && (id_ex_rw != '0);
  end

  // Priority: EX/MEM result, then MEM/WB, then the write retired last cycle.
  always_comb begin
    logic [RAW-1:0] op;
    op     = '0;
    f_ctrl = '0;
    if (rst_n) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        op = id_ex_src[i*RAW +: RAW];
        if (op != '0) begin
          if (ex_mem_regwrite && ex_mem_rw == op)
            f_ctrl[2*i +: 2] = 2'b01;
          else if (mem_wb_regwrite && mem_wb_rw == op)
            f_ctrl[2*i +: 2] = 2'b10;
          else if (hold_vld && hold_rw == op)
            f_ctrl[2*i +: 2] = 2'b11;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      bcnt  <= '0;
    end else if (!mem_busy) begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    case (state)
      RUN: begin
        if (load_use && LD_BUBBLES > 1) begin
          state_nxt = LDSTALL;
          bcnt_nxt  = BCNT_INIT;
        end
      end
      LDSTALL: begin
        bcnt_nxt = bcnt - 3'd1;
        if (bcnt == 3'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    freeze = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        freeze = 1'b1;
      end else if (state == LDSTALL || load_use) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_rw   <= '0;
      hold_vld  <= 1'b0;
      stall_cnt <= '0;
    end else if (!mem_busy) begin
      hold_rw  <= mem_wb_rw;
      hold_vld <= mem_wb_regwrite && (mem_wb_rw != '0);
      if (bubble && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  RAW  5  register-address width
  NSRC  2  source operands per instruction (1..4)
  LD_BUBBLES  1  bubbles per load-use hazard (1..7)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  synchronous, active-low reset
  id_ex_src  in  NSRC*RAW  EX-stage source addresses; operand i at [i*RAW +: RAW]
  if_id_src  in  NSRC*RAW  ID-stage source addresses, same packing
  id_ex_rw  in  RAW  EX-stage destination
  id_ex_memread  in  1  EX-stage instruction is a load
  ex_mem_rw  in  RAW  MEM-stage destination
  ex_mem_regwrite  in  1  MEM-stage writes register
  mem_wb_rw  in  RAW  WB-stage destination
  mem_wb_regwrite  in  1  WB-stage writes register
  mem_busy  in  1  data memory not ready
  f_ctrl  out  2*NSRC  forward select per operand, operand i at [2i+1:2i]
  stall  out  1  hold PC and IF/ID
  bubble  out  1  zero ID/EX control (insert NOP)
  freeze  out  1  hold entire pipeline
  stall_cnt  out  16  count of bubble cycles, saturating

Function
REQ-003 f_ctrl SHALL be combinational per operand, priority 01 > 10 > 11 > 00.
REQ-004 01 SHALL be selected when ex_mem_regwrite=1, ex_mem_rw!=0 and ex_mem_rw equals the operand.
REQ-005 10 SHALL be selected when mem_wb_regwrite=1, mem_wb_rw!=0 and mem_wb_rw equals the operand.
REQ-006 11 SHALL be selected when hold_vld=1 and hold_rw equals the operand (WB-hold bypass for the previous cycle's write).
REQ-007 hold_rw/hold_vld SHALL register mem_wb_rw / (mem_wb_regwrite && mem_wb_rw!=0) on each non-frozen edge; when freeze=1 they SHALL hold.
REQ-008 Operand address 0 SHALL always yield 00.
REQ-009 load_use SHALL be id_ex_memread && id_ex_rw!=0 && id_ex_rw equals any if_id_src operand.
REQ-010 The FSM SHALL have states RUN and LDSTALL, plus a 3-bit counter bcnt.
REQ-011 In RUN with load_use=1 and mem_busy=0: stall=1 and bubble=1 that cycle; if LD_BUBBLES>1, next state LDSTALL with bcnt=LD_BUBBLES-1, else remain RUN.
REQ-012 In LDSTALL: stall=1 and bubble=1; bcnt decrements each non-frozen cycle; exit to RUN on the edge where bcnt==1.
REQ-013 load_use SHALL be ignored while in LDSTALL.
REQ-014 mem_busy=1 SHALL force freeze=1, stall=0 and bubble=0 in any state.
REQ-015 While mem_busy=1, FSM state, bcnt, hold registers and stall_cnt SHALL not change.
REQ-016 mem_busy SHALL take priority over a simultaneous load_use, which is re-evaluated on the first cycle with mem_busy=0.
REQ-017 stall_cnt SHALL increment by 1 on each edge where bubble=1.
REQ-018 stall_cnt SHALL saturate at 16'hFFFF.
REQ-019 The outputs stall, bubble and freeze SHALL be 0 in RUN with no hazard and mem_busy=0.

Reset
REQ-020 rst_n=0 at a rising edge SHALL set the FSM to RUN, bcnt=0, hold_vld=0, hold_rw=0 and stall_cnt=0, aborting any LDSTALL in progress.
REQ-021 While rst_n=0, stall, bubble, freeze and all f_ctrl fields SHALL be driven 0.

Verification
REQ-022 Forwarding priority: id_ex_src op0=3, ex_mem_rw=3/regwrite=1, mem_wb_rw=3/regwrite=1 -> f_ctrl[1:0]=01; drop ex_mem_regwrite -> 10; next cycle with mem_wb_regwrite=0 -> 11; operand 0 with all matches -> 00.
REQ-023 Load-use, LD_BUBBLES=3: id_ex_memread=1, id_ex_rw=7, if_id_src op1=7 -> stall=bubble=1 for exactly 3 cycles, then 0; stall_cnt=3.
REQ-024 Busy during stall: LD_BUBBLES=3, mem_busy=1 for 2 cycles after the first bubble -> freeze=1, stall=bubble=0 for those 2 cycles; total bubbles still 3.
REQ-025 Reset mid-LDSTALL: rst_n=0 for one edge in bcnt=2 -> next cycle RUN, outputs 0, stall_cnt=0.
REQ-026 Saturation: preload by running 65,535 bubbles, then one more load-use -> stall_cnt remains 16'hFFFF.
